reg_file_32x32: RTL

Architectural MIPS register file: 32 general-purpose registers, two combinational read ports and one synchronous write port. It sits directly downstream of the 5-bit write-register select mux (RegDst, rt vs rd), which drives its write address. Read ports feed the ID stage operands. A same-cycle write-to-read bypass gives the classic "write first half, read second half" behaviour in a single-edge design.

---
 rtl/reg_file_32x32.sv | 73 +++++++
 1 files changed

// File: rtl/reg_file_32x32.sv
// MIPS architectural register file: two combinational read ports with
// same-cycle write bypass, one synchronous write port, raw debug read.
module reg_file_32x32 #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              Clk_40,
    input  logic              Rst_n_40,
    input  logic              RegWrite_40,
    input  logic [ADDR_W-1:0] WriteReg_40,
    input  logic [DATA_W-1:0] WriteData_40,
    input  logic [ADDR_W-1:0] ReadReg1_40,
    input  logic [ADDR_W-1:0] ReadReg2_40,
    output logic [DATA_W-1:0] ReadData1_40,
    output logic [DATA_W-1:0] ReadData2_40,
    input  logic [ADDR_W-1:0] DbgAddr_40,
    output logic [DATA_W-1:0] DbgData_40
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic              wr_en;

    // r0 is never a write target, so it stays at its reset value of zero.
    assign wr_en = RegWrite_40 && (WriteReg_40 != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[WriteReg_40] = WriteData_40;
        end
    end

    always_ff @(posedge Clk_40) begin
        if (!Rst_n_40) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Both read ports share one structure; index 0 is port 1, index 1 is port 2.
    logic [ADDR_W-1:0] rd_addr [2];
    logic [DATA_W-1:0] rd_data [2];

    assign rd_addr[0]   = ReadReg1_40;
    assign rd_addr[1]   = ReadReg2_40;
    assign ReadData1_40 = rd_data[0];
    assign ReadData2_40 = rd_data[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd_port
            always_comb begin
                rd_data[gi] = '0;
                if (!Rst_n_40 || (rd_addr[gi] == '0)) begin
                    rd_data[gi] = '0;
                end else if (RegWrite_40 && (WriteReg_40 == rd_addr[gi])) begin
                    rd_data[gi] = WriteData_40;
                end else begin
                    rd_data[gi] = regs_q[rd_addr[gi]];
                end
            end
        end
    endgenerate

    // Debug view shows stored contents only: no reset gating, no bypass.
    assign DbgData_40 = (DbgAddr_40 == '0) ? '0 : regs_q[DbgAddr_40];

endmodule
